vid_raster_out: RTL and testbench
=================================

// Module: vid_raster_out
// PURPOSE
//  Pixel output stage downstream of the video fetch/FIFO block. Generates programmable
//  raster timing (hsync/hblank/vsync/vblank) from the control/timing registers. Pops one
//  RGB entry from the red/green/blue pixel FIFOs per displayed pixel and drives R/G/B.
//  Pulses line_req so the fetch engine prefetches the next displayed line during hblank.
// PARAMETERS
//  CW   13  width of horizontal/vertical counters and timing fields
//  PDW  6   width of pixel clock divider field (pcnt)
// PORTS
//  clk          in   1    clock
//  reset_n      in   1    asynchronous, active-low reset
//  en           in   1    controller enable (cr.en)
//  pcnt         in   PDW  pixel divider; one pixel tick every pcnt+1 clocks
//  hend/hsize   in   CW   total / displayed pixels per line
//  hsync_start  in   CW   first pixel with hsync high
//  hsync_end    in   CW   first pixel after hsync (exclusive)
//  vend/vsize   in   CW   total / displayed lines per frame
//  vsync_start  in   CW   first line with vsync high
//  vsync_end    in   CW   first line after vsync (exclusive)
//  fifo_empty   in   1    pixel FIFOs empty (red/green/blue advance in lockstep)
//  fifo_r/g/b   in   8    FIFO head data (combinational, valid while !fifo_empty)
//  fifo_read    out  1    pop strobe, one clk wide, to all three FIFOs
//  line_req     out  1    one-clk pulse: fetch line line_num now
//  line_num     out  CW   line index for line_req; held until the next pulse
//  frame_start  out  1    one-clk pulse at the first pixel tick of each frame
//  hsync/hblank out  1    horizontal sync / blank
//  vsync/vblank out  1    vertical sync / blank
//  R/G/B        out  8    pixel data; 0 whenever blanked
//  underflow    out  1    sticky: active pixel ticked while FIFO empty
//  underflow_clr in  1    synchronous clear of underflow
// BEHAVIOUR
//  Reset values: fifo_read=0, line_req=0, line_num=0, frame_start=0, hsync=0, vsync=0,
//   hblank=1, vblank=1, R=G=B=0, underflow=0. FSM=IDLE. Counters div/hcnt/vcnt=0.
//  FSM IDLE: outputs hold their reset values. Go to RUN when en=1, hend!=0 and vend!=0.
//   On that transition, shadow all timing inputs and pcnt.
//  FSM RUN: return to IDLE on the next clk when en=0. Clear counters and outputs to reset
//   values, except underflow.
//  Shadowing: timing fields are re-sampled only at the frame wrap tick, so mid-frame writes
//   take effect on the next frame.
//  Divider: div counts 0..pcnt and wraps. tick = (div==pcnt). With pcnt=0, tick every clk.
//  Counters advance on tick only:
//   - hcnt wraps at hend-1.
//   - vcnt increments when hcnt wraps, and wraps at vend-1.
//   - Comparisons are unsigned, CW bits.
//  Classification of the current tick (hcnt,vcnt):
//   - act = hcnt<hsize && vcnt<vsize.
//   - hs  = hsync_start<=hcnt<hsync_end.
//   - vs  = vsync_start<=vcnt<vsync_end.
//  Outputs are registered on the tick clk and are visible 1 clk after the tick. They hold
//   between ticks.
//   - hblank  <= !(hcnt<hsize)
//   - vblank  <= !(vcnt<vsize)
//   - hsync   <= hs
//   - vsync   <= vs
//  Pixel pop (combinational in the tick clk):
//   - fifo_read = tick & act & !fifo_empty.
//   - Same edge: R/G/B <= fifo_r/g/b if popped, else 0.
//   - act with fifo_empty: no pop, R/G/B<=0, underflow<=1.
//  Underflow precedence: a set and underflow_clr in the same clk leaves underflow=1.
//  line_req:
//   - Pulses at the tick where hcnt==hsize (or hcnt==0 when hsize==0) and the next line
//     nl<vsize, where nl = (vcnt==vend-1)?0:vcnt+1.
//   - line_num <= nl on the same edge.
//   - First frame: line 0 is requested on the clk after IDLE->RUN, before any tick.
//  frame_start: pulses at the tick with hcnt==0 and vcnt==0.
//  Degenerate configurations:
//   - hsync_start>=hsync_end gives hsync never high; likewise vsync.
//   - hsize>hend gives every pixel active; likewise vsize>vend.
//  Reset asserted mid-frame forces all outputs to reset values asynchronously. No FIFO pop.
// TESTING
//  T1 Timing, pcnt=0: hend=10,hsize=6,hsync 7..9,vend=5,vsize=3,vsync 3..4.
//     -> hblank low 6 of every 10 clks; hsync high 2 clks/line.
//     -> vblank low lines 0-2; vsync high on line 3; period 50 clks.
//  T2 Divider: pcnt=4, T1 timing.
//     -> every output changes only at 5-clk boundaries; line period 50 clks.
//  T3 Pixel data: FIFO preloaded with 0x10..0x2F ramp, T1 timing.
//     -> R/G/B show 0x10,0x11.. in active pixels; 0 in blanking.
//     -> exactly 18 pops per frame; underflow stays 0.
//  T4 Underflow: FIFO holds 3 entries, hsize=6.
//     -> pixels 3-5 output 0; underflow=1; no fifo_read while empty.
//     -> underflow_clr -> 0.
//  T5 line_req: T1 timing.
//     -> pulses with line_num=1,2 at hcnt==6 of lines 0,1; line_num=0 at hcnt==6 of line 4.
//     -> no pulse on lines 2,3.
//  T6 Enable/reset: en=0 mid-line -> next clk hblank=vblank=1, R/G/B=0.
//     -> re-enable restarts at hcnt=vcnt=0 with line_req(0).
//     -> reset_n low mid-pixel -> immediate reset values.

Source files
------------

// File: rtl/vid_raster_out_if.sv
// Pixel FIFO port bundle between the pixel output stage and the red/green/blue pixel FIFOs.
// master: the raster stage, which pops. slave: the FIFO side, which presents head data.
// fifo_empty/fifo_r/g/b are the FIFO head (combinational); fifo_read is a one-clk pop strobe.
interface vid_raster_out_if;
  logic       fifo_empty;
  logic [7:0] fifo_r;
  logic [7:0] fifo_g;
  logic [7:0] fifo_b;
  logic       fifo_read;

  modport master (
    input  fifo_empty,
    input  fifo_r,
    input  fifo_g,
    input  fifo_b,
    output fifo_read
  );

  modport slave (
    output fifo_empty,
    output fifo_r,
    output fifo_g,
    output fifo_b,
    input  fifo_read
  );
endinterface

// File: rtl/vid_raster_out.sv
// Raster timing generator and pixel output stage: hsync/hblank/vsync/vblank, RGB from the pixel FIFOs,
// and line prefetch requests. Latency: outputs register on the pixel tick, visible 1 clk later.
// Backpressure: none accepted; an active pixel that meets an empty FIFO outputs black and sets underflow.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   en                    controller enable; IDLE->RUN needs en and non-zero hend/vend
//   pcnt                  pixel divider, one tick every pcnt+1 clocks
//   hend/hsize/hsync_*    horizontal total, displayed width, sync window [start,end)
//   vend/vsize/vsync_*    vertical total, displayed height, sync window [start,end)
//   pix                   pixel FIFO bundle (head data, empty, pop strobe)
//   line_req/line_num     one-clk prefetch request for line line_num
//   frame_start           one-clk pulse for the first pixel of each frame
//   hsync/hblank/vsync/vblank, R/G/B   video outputs (RGB black while blanked)
//   underflow/underflow_clr            sticky underflow flag and its clear
module vid_raster_out #(
  parameter int CW  = 13,
  parameter int PDW = 6
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic [PDW-1:0]  pcnt,
  input  logic [CW-1:0]   hend,
  input  logic [CW-1:0]   hsize,
  input  logic [CW-1:0]   hsync_start,
  input  logic [CW-1:0]   hsync_end,
  input  logic [CW-1:0]   vend,
  input  logic [CW-1:0]   vsize,
  input  logic [CW-1:0]   vsync_start,
  input  logic [CW-1:0]   vsync_end,
  vid_raster_out_if.master pix,
  output logic            line_req,
  output logic [CW-1:0]   line_num,
  output logic            frame_start,
  output logic            hsync,
  output logic            hblank,
  output logic            vsync,
  output logic            vblank,
  output logic [7:0]      R,
  output logic [7:0]      G,
  output logic [7:0]      B,
  output logic            underflow,
  input  logic            underflow_clr
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state_q, state_d;

  // Strobes from the FSM: start = IDLE->RUN edge, stop = RUN->IDLE edge, run = counting normally.
  logic start, stop, run;

  // Shadowed timing, so a register write mid-frame only lands at the next frame.
  logic [PDW-1:0] pcnt_s;
  logic [CW-1:0]  hend_s, hsize_s, hss_s, hse_s;
  logic [CW-1:0]  vend_s, vsize_s, vss_s, vse_s;

  logic [PDW-1:0] div_q;
  logic [CW-1:0]  hcnt_q, vcnt_q;

  logic           tick;
  logic           h_last, v_last, frame_wrap;
  logic           h_act, v_act, act;
  logic           hs, vs;
  logic [CW-1:0]  next_line;
  logic           lreq_hit;
  logic           pop, uf_set;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    stop    = 1'b0;
    run     = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && (hend != '0) && (vend != '0)) begin
          state_d = RUN;
          start   = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          stop    = 1'b1;
        end else begin
          run = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- classification of the current position
  assign tick       = run && (div_q == pcnt_s);
  assign h_last     = (hcnt_q == hend_s - CW'(1));
  assign v_last     = (vcnt_q == vend_s - CW'(1));
  assign frame_wrap = tick && h_last && v_last;

  assign h_act = (hcnt_q < hsize_s);
  assign v_act = (vcnt_q < vsize_s);
  assign act   = h_act && v_act;

  // An empty or inverted window never matches, so sync stays low.
  assign hs = (hcnt_q >= hss_s) && (hcnt_q < hse_s);
  assign vs = (vcnt_q >= vss_s) && (vcnt_q < vse_s);

  // Prefetch fires on the first blanked pixel of the line, asking for the line after this one.
  assign next_line = v_last ? '0 : vcnt_q + CW'(1);
  assign lreq_hit  = (hcnt_q == hsize_s) && (next_line < vsize_s);

  assign pop           = tick && act && !pix.fifo_empty;
  assign uf_set        = tick && act &&  pix.fifo_empty;
  assign pix.fifo_read = pop;

  // ---------------------------------------------------------------- timing shadow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_s  <= '0;
      hend_s  <= '0;
      hsize_s <= '0;
      hss_s   <= '0;
      hse_s   <= '0;
      vend_s  <= '0;
      vsize_s <= '0;
      vss_s   <= '0;
      vse_s   <= '0;
    end else if (start || frame_wrap) begin
      pcnt_s  <= pcnt;
      hend_s  <= hend;
      hsize_s <= hsize;
      hss_s   <= hsync_start;
      hse_s   <= hsync_end;
      vend_s  <= vend;
      vsize_s <= vsize;
      vss_s   <= vsync_start;
      vse_s   <= vsync_end;
    end
  end

  // ---------------------------------------------------------------- counters and video outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q       <= '0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      line_req    <= 1'b0;
      line_num    <= '0;
      frame_start <= 1'b0;
      hsync       <= 1'b0;
      hblank      <= 1'b1;
      vsync       <= 1'b0;
      vblank      <= 1'b1;
      R           <= '0;
      G           <= '0;
      B           <= '0;
    end else if (start) begin
      div_q       <= '0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      // Line 0 has no preceding hblank to prefetch in, so ask for it straight away.
      line_req    <= (vsize != '0);
      line_num    <= '0;
      frame_start <= 1'b0;
    end else if (stop) begin
      div_q       <= '0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      line_req    <= 1'b0;
      line_num    <= '0;
      frame_start <= 1'b0;
      hsync       <= 1'b0;
      hblank      <= 1'b1;
      vsync       <= 1'b0;
      vblank      <= 1'b1;
      R           <= '0;
      G           <= '0;
      B           <= '0;
    end else if (run) begin
      line_req    <= 1'b0;
      frame_start <= 1'b0;
      if (tick) begin
        div_q  <= '0;
        hcnt_q <= h_last ? '0 : hcnt_q + CW'(1);
        if (h_last) vcnt_q <= v_last ? '0 : vcnt_q + CW'(1);
        hblank <= !h_act;
        vblank <= !v_act;
        hsync  <= hs;
        vsync  <= vs;
        R      <= pop ? pix.fifo_r : 8'h00;
        G      <= pop ? pix.fifo_g : 8'h00;
        B      <= pop ? pix.fifo_b : 8'h00;
        if (lreq_hit) begin
          line_req <= 1'b1;
          line_num <= next_line;
        end
        frame_start <= (hcnt_q == '0) && (vcnt_q == '0);
      end else begin
        div_q <= div_q + PDW'(1);
      end
    end
  end

  // Set wins over clear so an underflow in the clearing clk is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          underflow <= 1'b0;
    else if (uf_set)       underflow <= 1'b1;
    else if (underflow_clr) underflow <= 1'b0;
  end

endmodule

// File: tb/tb_vid_raster_out.sv
module tb_vid_raster_out;
  localparam int CW  = 13;
  localparam int PDW = 6;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b0;
  logic          underflow_clr = 1'b0;
  logic [PDW-1:0] pcnt;
  logic [CW-1:0] hend, hsize, hsync_start, hsync_end;
  logic [CW-1:0] vend, vsize, vsync_start, vsync_end;
  logic          line_req, frame_start, hsync, hblank, vsync, vblank, underflow;
  logic [CW-1:0] line_num;
  logic [7:0]    R, G, B;

  vid_raster_out_if pix();

  vid_raster_out #(.CW(CW), .PDW(PDW)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .pcnt(pcnt),
    .hend(hend), .hsize(hsize), .hsync_start(hsync_start), .hsync_end(hsync_end),
    .vend(vend), .vsize(vsize), .vsync_start(vsync_start), .vsync_end(vsync_end),
    .pix(pix),
    .line_req(line_req), .line_num(line_num), .frame_start(frame_start),
    .hsync(hsync), .hblank(hblank), .vsync(vsync), .vblank(vblank),
    .R(R), .G(G), .B(B), .underflow(underflow), .underflow_clr(underflow_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p, hend, hsize, hss, hse, vend, vsize, vss, vse;
  } cfg_t;

  typedef struct packed {
    logic          line_req;
    logic [CW-1:0] line_num;
    logic          frame_start, hsync, hblank, vsync, vblank;
    logic [7:0]    r, g, b;
    logic          uf;
  } obs_t;

  typedef struct {
    cfg_t c;
    int   fill;
    int   pops, hs_clks, hact_clks, vs_clks, vact_clks, lreqs;
    bit   uf;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  cfg_t cfg;
  logic [23:0] q[$];

  // Reference model: frame position as a linear tick index within the frame.
  bit   m_run;
  int   m_sub, m_pos;
  cfg_t mc;
  obs_t exp_o;
  bit   exp_read;

  bit   counting;
  int   w_pops, w_hs, w_hact, w_vs, w_vact, w_lreq;

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.hblank = 1'b1;
    o.vblank = 1'b1;
    return o;
  endfunction

  function automatic obs_t get_obs();
    obs_t o;
    o = {line_req, line_num, frame_start, hsync, hblank, vsync, vblank, R, G, B, underflow};
    return o;
  endfunction

  function automatic string obs_str(obs_t o);
    return $sformatf("lr=%b ln=%0d fs=%b hs=%b hb=%b vs=%b vb=%b rgb=%h%h%h uf=%b",
                     o.line_req, o.line_num, o.frame_start, o.hsync, o.hblank,
                     o.vsync, o.vblank, o.r, o.g, o.b, o.uf);
  endfunction

  task automatic chk_int(string name, int got, int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic chk_obs(string name, obs_t got, obs_t want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0t: got {%s} expected {%s}", name, $time, obs_str(got), obs_str(want));
    end
  endtask

  task automatic drive_cfg();
    pcnt        = PDW'(cfg.p);
    hend        = CW'(cfg.hend);
    hsize       = CW'(cfg.hsize);
    hsync_start = CW'(cfg.hss);
    hsync_end   = CW'(cfg.hse);
    vend        = CW'(cfg.vend);
    vsize       = CW'(cfg.vsize);
    vsync_start = CW'(cfg.vss);
    vsync_end   = CW'(cfg.vse);
  endtask

  task automatic fifo_drive();
    pix.fifo_empty = (q.size() == 0);
    if (q.size() > 0) {pix.fifo_r, pix.fifo_g, pix.fifo_b} = q[0];
    else              {pix.fifo_r, pix.fifo_g, pix.fifo_b} = 24'hA5C35A;
  endtask

  function automatic void model_reset();
    m_run    = 1'b0;
    m_sub    = 0;
    m_pos    = 0;
    exp_o    = reset_obs();
    exp_read = 1'b0;
  endfunction

  // Predicts the effect of the coming clock edge from the inputs now present.
  function automatic void model_step();
    bit set_uf;
    bit keep_uf;
    int h, v, nl;
    bit ha, va;
    set_uf   = 1'b0;
    exp_read = 1'b0;
    if (!m_run) begin
      if (en && cfg.hend != 0 && cfg.vend != 0) begin
        m_run = 1'b1;
        mc    = cfg;
        m_sub = 0;
        m_pos = 0;
        exp_o.line_req = (cfg.vsize != 0);
        exp_o.line_num = '0;
      end
    end else if (!en) begin
      m_run   = 1'b0;
      keep_uf = exp_o.uf;
      exp_o   = reset_obs();
      exp_o.uf = keep_uf;
    end else begin
      exp_o.line_req    = 1'b0;
      exp_o.frame_start = 1'b0;
      if (m_sub == mc.p) begin
        h  = m_pos % mc.hend;
        v  = m_pos / mc.hend;
        ha = (h < mc.hsize);
        va = (v < mc.vsize);
        exp_o.hblank = !ha;
        exp_o.vblank = !va;
        exp_o.hsync  = (h >= mc.hss) && (h < mc.hse);
        exp_o.vsync  = (v >= mc.vss) && (v < mc.vse);
        {exp_o.r, exp_o.g, exp_o.b} = 24'h0;
        if (ha && va) begin
          if (q.size() > 0) begin
            exp_read = 1'b1;
            {exp_o.r, exp_o.g, exp_o.b} = q[0];
          end else begin
            set_uf = 1'b1;
          end
        end
        nl = (v == mc.vend - 1) ? 0 : v + 1;
        if (h == mc.hsize && nl < mc.vsize) begin
          exp_o.line_req = 1'b1;
          exp_o.line_num = CW'(nl);
        end
        exp_o.frame_start = (m_pos == 0);
        m_sub = 0;
        m_pos++;
        if (m_pos == mc.hend * mc.vend) begin
          m_pos = 0;
          mc    = cfg;
        end
      end else begin
        m_sub++;
      end
    end
    if (set_uf)             exp_o.uf = 1'b1;
    else if (underflow_clr) exp_o.uf = 1'b0;
  endfunction

  // One clock: predict and check the pop strobe mid-cycle, then check registered outputs after the edge.
  task automatic cycle();
    bit pop_seen;
    obs_t o;
    @(negedge clk);
    model_step();
    n_chk++;
    if (pix.fifo_read !== exp_read) begin
      n_fail++;
      $display("FAIL fifo_read @%0t: got %b expected %b", $time, pix.fifo_read, exp_read);
    end
    pop_seen = (pix.fifo_read === 1'b1);
    @(posedge clk);
    #1;
    if (pop_seen && q.size() > 0) void'(q.pop_front());
    fifo_drive();
    o = get_obs();
    chk_obs("outputs", o, exp_o);
    if (counting) begin
      w_pops += int'(pop_seen);
      w_hs   += int'(o.hsync);
      w_hact += int'(!o.hblank);
      w_vs   += int'(o.vsync);
      w_vact += int'(!o.vblank);
      w_lreq += int'(o.line_req);
    end
  endtask

  task automatic fill_ramp(int n);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back({8'(16 + i), 8'(80 + i), 8'(144 + i)});
    fifo_drive();
  endtask

  task automatic run_record(vec_t v, int idx);
    int f;
    fill_ramp(v.fill);
    cfg = v.c;
    drive_cfg();
    en = 1'b1;
    cycle();
    repeat (v.c.p) cycle();
    w_pops = 0; w_hs = 0; w_hact = 0; w_vs = 0; w_vact = 0; w_lreq = 0;
    counting = 1'b1;
    f = (v.c.p + 1) * v.c.hend * v.c.vend;
    repeat (f) cycle();
    counting = 1'b0;
    chk_int($sformatf("rec%0d pops", idx), w_pops, v.pops);
    chk_int($sformatf("rec%0d hsync_clks", idx), w_hs, v.hs_clks);
    chk_int($sformatf("rec%0d hactive_clks", idx), w_hact, v.hact_clks);
    chk_int($sformatf("rec%0d vsync_clks", idx), w_vs, v.vs_clks);
    chk_int($sformatf("rec%0d vactive_clks", idx), w_vact, v.vact_clks);
    chk_int($sformatf("rec%0d line_reqs", idx), w_lreq, v.lreqs);
    chk_int($sformatf("rec%0d underflow", idx), int'(underflow), int'(v.uf));
    en = 1'b0;
    cycle();
    underflow_clr = 1'b1;
    cycle();
    underflow_clr = 1'b0;
    chk_int($sformatf("rec%0d underflow_clr", idx), int'(underflow), 0);
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.p     = $urandom_range(0, 3);
    c.hend  = $urandom_range(1, 12);
    c.hsize = $urandom_range(0, 14);
    c.hss   = $urandom_range(0, 13);
    c.hse   = $urandom_range(0, 13);
    c.vend  = $urandom_range(1, 6);
    c.vsize = $urandom_range(0, 7);
    c.vss   = $urandom_range(0, 7);
    c.vse   = $urandom_range(0, 7);
    return c;
  endfunction

  vec_t tbl[5];
  cfg_t t1;

  initial begin
    t1 = '{p:0, hend:10, hsize:6, hss:7, hse:9, vend:5, vsize:3, vss:3, vse:4};
    tbl[0] = '{c:t1, fill:32, pops:18, hs_clks:10, hact_clks:30, vs_clks:10, vact_clks:30, lreqs:3, uf:1'b0};
    tbl[1] = '{c:t1, fill:32, pops:18, hs_clks:50, hact_clks:150, vs_clks:50, vact_clks:150, lreqs:3, uf:1'b0};
    tbl[1].c.p = 4;
    tbl[2] = '{c:'{p:1, hend:8, hsize:10, hss:5, hse:5, vend:4, vsize:2, vss:3, vse:1},
               fill:40, pops:16, hs_clks:0, hact_clks:64, vs_clks:0, vact_clks:32, lreqs:0, uf:1'b0};
    tbl[3] = '{c:t1, fill:3, pops:3, hs_clks:10, hact_clks:30, vs_clks:10, vact_clks:30, lreqs:3, uf:1'b1};
    tbl[4] = '{c:'{p:2, hend:6, hsize:0, hss:0, hse:6, vend:3, vsize:3, vss:1, vse:2},
               fill:8, pops:0, hs_clks:54, hact_clks:0, vs_clks:18, vact_clks:54, lreqs:3, uf:1'b0};

    counting = 1'b0;
    cfg = t1;
    drive_cfg();
    q.delete();
    fifo_drive();
    model_reset();

    // Values while held in reset.
    #23;
    chk_obs("reset_outputs", get_obs(), reset_obs());
    chk_int("reset_fifo_read", int'(pix.fifo_read), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle();

    foreach (tbl[i]) run_record(tbl[i], i);

    // Enable drop mid-line, then restart from the top with an immediate line 0 request.
    cfg = t1;
    drive_cfg();
    fill_ramp(32);
    en = 1'b1;
    repeat (24) cycle();
    en = 1'b0;
    cycle();
    chk_int("en_off hblank", int'(hblank), 1);
    chk_int("en_off vblank", int'(vblank), 1);
    chk_int("en_off rgb", int'({R, G, B}), 0);
    en = 1'b1;
    cycle();
    chk_int("restart line_req", int'(line_req), 1);
    chk_int("restart line_num", int'(line_num), 0);
    cycle();
    chk_int("restart frame_start", int'(frame_start), 1);
    repeat (10) cycle();

    // Asynchronous reset in the middle of a divided pixel.
    cfg.p = 3;
    drive_cfg();
    en = 1'b0;
    cycle();
    en = 1'b1;
    repeat (30) cycle();
    #2;
    reset_n = 1'b0;
    #1;
    chk_obs("async_reset_outputs", get_obs(), reset_obs());
    chk_int("async_reset_fifo_read", int'(pix.fifo_read), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    fifo_drive();
    repeat (40) cycle();
    en = 1'b0;
    cycle();

    // Randomised traffic: enable drops, mid-frame timing writes, FIFO refills and underflow clears.
    for (int r = 0; r < 6; r++) begin
      cfg = rand_cfg();
      drive_cfg();
      q.delete();
      for (int k = 0; k < int'($urandom_range(0, 20)); k++) q.push_back(24'($urandom));
      fifo_drive();
      en = 1'b1;
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 99) == 0) en = ~en;
        else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
        underflow_clr = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 149) == 0) begin
          cfg = rand_cfg();
          drive_cfg();
        end
        if ($urandom_range(0, 9) == 0) begin
          for (int k = 0; k < int'($urandom_range(1, 8)); k++) q.push_back(24'($urandom));
          fifo_drive();
        end
        cycle();
      end
      underflow_clr = 1'b0;
      en = 1'b0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish within its time budget");
    $fatal(1, "timeout");
  end

endmodule
